// File: rtl/fifo_if_pkg.sv
// Shared definitions for the SRAM-backed FIFO interface and its upstream write master.
// Holds the write-master state encoding, the FIFO data/SRAM address widths, and the
// minimum strobe/hold durations that the FIFO interface relies on.
package fifo_if_pkg;

    // Write-master states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int unsigned FIFO_DW        = 8;
    localparam int unsigned SRAM_AW        = 11;
    localparam int unsigned MIN_STROBE_CYC = 2;
    localparam int unsigned MIN_HOLD_CYC   = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_wm_timer.sv
// Loadable down-counter with a zero flag; times the strobe and hold phases.
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous reset, active-high (count -> 0)
//   i_load     load i_load_val (has priority over i_dec)
//   i_load_val value to load
//   i_dec      decrement by one; holds at zero
//   o_zero     count is zero
module fifo_wm_timer #(
    parameter int unsigned W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/fifo_write_master.sv
// Upstream stage of the SRAM-backed FIFO interface. Takes bytes from a valid/ready stream
// and replays each as an active-low write strobe with stable data, gated by nfull.
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_s_data       upstream byte
//   i_s_valid      upstream byte valid
//   o_s_ready      block can accept a byte this cycle (combinational)
//   o_in_data      data bus to the FIFO interface
//   o_fifowr       FIFO write strobe, active-low
//   i_nfull        FIFO not-full flag
//   o_busy         a byte is in flight
//   o_wr_count     completed writes, wraps
//   o_stall_count  cycles stalled in SETUP on a full FIFO, saturates
module fifo_write_master
    import fifo_if_pkg::*;
#(
    parameter int unsigned DW         = FIFO_DW,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DW-1:0]    i_s_data,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    output logic [DW-1:0]    o_in_data,
    output logic             o_fifowr,
    input  logic             i_nfull,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_wr_count,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam int unsigned TW = $clog2(max_u(STROBE_CYC, HOLD_CYC) + 1);

    if (STROBE_CYC < MIN_STROBE_CYC) begin : g_bad_strobe
        $error("fifo_write_master: STROBE_CYC must be >= 2");
    end
    if (HOLD_CYC < MIN_HOLD_CYC) begin : g_bad_hold
        $error("fifo_write_master: HOLD_CYC must be >= 2");
    end

    state_t            r_state;
    state_t            w_state_d;
    logic [DW-1:0]     r_buf;
    logic [DW-1:0]     r_in_data;
    logic              r_fifowr;
    logic              r_busy;
    logic [CNT_W-1:0]  r_wr_count;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_accept;
    logic              w_stall;
    logic              w_wr_done;
    logic              w_tmr_load;
    logic [TW-1:0]     w_tmr_load_val;
    logic              w_tmr_dec;
    logic              w_tmr_zero;

    fifo_wm_timer #(
        .W (TW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    assign o_s_ready = (r_state == IDLE) & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Timer is loaded with N-1 on phase entry so the phase lasts N cycles including
    // the cycle in which the zero flag is seen.
    always_comb begin
        w_state_d      = r_state;
        w_accept       = 1'b0;
        w_stall        = 1'b0;
        w_wr_done      = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = '0;
        w_tmr_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_s_valid && o_s_ready) begin
                    w_accept  = 1'b1;
                    w_state_d = SETUP;
                end
            end
            SETUP: begin
                if (i_nfull) begin
                    w_state_d      = STROBE;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = TW'(STROBE_CYC - 1);
                end else begin
                    w_stall = 1'b1;
                end
            end
            STROBE: begin
                if (w_tmr_zero) begin
                    w_state_d      = HOLD;
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = TW'(HOLD_CYC - 1);
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            HOLD: begin
                if (w_tmr_zero) begin
                    w_state_d = IDLE;
                    w_wr_done = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Registered outputs lag the state by one cycle: in_data is driven one cycle before
    // fifowr falls, and fifowr rises while in_data is still held for the HOLD phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf         <= '0;
            r_in_data     <= '0;
            r_fifowr      <= 1'b1;
            r_busy        <= 1'b0;
            r_wr_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_accept) begin
                r_buf <= i_s_data;
            end
            if (r_state == SETUP) begin
                r_in_data <= r_buf;
            end
            r_fifowr <= (r_state != STROBE);
            r_busy   <= (w_state_d != IDLE);
            if (w_wr_done) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign o_in_data     = r_in_data;
    assign o_fifowr      = r_fifowr;
    assign o_busy        = r_busy;
    assign o_wr_count    = r_wr_count;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_fifo_write_master.sv
module tb_fifo_write_master;

    localparam int unsigned DW = 8;
    localparam int unsigned SC = 2;
    localparam int unsigned HC = 2;
    localparam int unsigned CW = 5;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] in_data;
    logic          fifowr;
    logic          nfull;
    logic          busy;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] stall_count;

    fifo_write_master #(
        .DW         (DW),
        .STROBE_CYC (SC),
        .HOLD_CYC   (HC),
        .CNT_W      (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_s_data      (s_data),
        .i_s_valid     (s_valid),
        .o_s_ready     (s_ready),
        .o_in_data     (in_data),
        .o_fifowr      (fifowr),
        .i_nfull       (nfull),
        .o_busy        (busy),
        .o_wr_count    (wr_count),
        .o_stall_count (stall_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model: bytes in accepted order, plus plain integer write/stall tallies.
    logic [DW-1:0] exp_q[$];
    int            fall_cyc[$];
    int            exp_wr    = 0;
    int            exp_stall = 0;

    // Monitor state.
    logic          prev_fw   = 1'b1;
    logic          rst_seen  = 1'b0;
    int            low_len   = 0;
    int            hold_left = 0;
    logic [DW-1:0] strobe_d  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters();
        check("wr_count", 32'(wr_count), 32'(exp_wr % (MAXC + 1)));
        check("stall_count", 32'(stall_count), 32'((exp_stall > MAXC) ? MAXC : exp_stall));
    endtask

    task automatic mon_step();
        logic [DW-1:0] e;
        if (rst || rst_seen) begin
            low_len   = 0;
            hold_left = 0;
            prev_fw   = 1'b1;
        end else begin
            if (prev_fw && !fifowr) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL strobe_unexpected: in_data=%0h, required no strobe", in_data);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_data", 32'(in_data), 32'(e));
                end
                strobe_d = in_data;
                low_len  = 1;
                fall_cyc.push_back(cyc);
            end else if (!fifowr) begin
                low_len++;
                check("data_stable_low", 32'(in_data), 32'(strobe_d));
            end else if (!prev_fw) begin
                check("strobe_width", 32'(low_len), 32'(SC));
                check("data_hold", 32'(in_data), 32'(strobe_d));
                hold_left = HC - 1;
            end else if (hold_left > 0) begin
                check("data_hold", 32'(in_data), 32'(strobe_d));
                hold_left--;
            end
            prev_fw = fifowr;
        end
        rst_seen = rst;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 300) begin
            step();
            g++;
        end
        if (g >= 300) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0b, required 0 within 300 cycles", busy);
        end
        repeat (3) step();
    endtask

    // Offers one byte; holds nfull low for `stall` SETUP samples after acceptance.
    task automatic send(input logic [DW-1:0] d, input int stall);
        int g = 0;
        while (!s_ready && g < 300) begin
            step();
            g++;
        end
        if (g >= 300) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: s_ready=%0b, required 1 within 300 cycles", s_ready);
            return;
        end
        s_data  = d;
        s_valid = 1'b1;
        nfull   = (stall == 0);
        exp_q.push_back(d);
        exp_wr++;
        exp_stall += stall;
        step();
        s_valid = 1'b0;
        for (int k = 0; k < stall; k++) begin
            step();
            check("fifowr_stalled", 32'(fifowr), 32'd1);
        end
        nfull = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] seq [0:5];
        int idx;
        logic acc;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        nfull   = 1'b1;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state
        step();
        step();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_in_data", 32'(in_data), 32'd0);
        check("rst_fifowr", 32'(fifowr), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check_counters();
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 32'(s_ready), 32'd1);

        // 1. Single byte with exact cycle timing
        s_data  = 8'hA5;
        s_valid = 1'b1;
        exp_q.push_back(8'hA5);
        exp_wr++;
        step();                       // edge 0 accepts
        s_valid = 1'b0;
        seq[1] = 1; seq[2] = 0; seq[3] = 0; seq[4] = 1; seq[5] = 1;
        for (int e = 1; e <= 5; e++) begin
            step();
            check($sformatf("t1_fifowr_e%0d", e), 32'(fifowr), 32'(seq[e]));
            if (e == 1) check("t1_in_data", 32'(in_data), 32'h00A5);
        end
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_s_ready", 32'(s_ready), 32'd1);
        check_counters();
        wait_idle();

        // 2. Back-to-back 01..10 with s_valid held
        fall_cyc.delete();
        idx     = 1;
        s_data  = 8'(idx);
        s_valid = 1'b1;
        for (int g = 0; g < 200 && idx <= 16; g++) begin
            acc = s_ready;
            step();
            if (acc) begin
                exp_q.push_back(8'(idx));
                exp_wr++;
                idx++;
                s_data = 8'(idx);
            end
        end
        s_valid = 1'b0;
        wait_idle();
        check("t2_strobes", 32'(fall_cyc.size()), 32'd16);
        for (int i = 1; i < fall_cyc.size(); i++)
            check("t2_spacing", 32'(fall_cyc[i] - fall_cyc[i-1]), 32'(2 + SC + HC));
        check_counters();

        // 3. Full stall for 20 cycles
        send(8'h3C, 20);
        wait_idle();
        check_counters();

        // 4. nfull falls during STROBE
        send(8'h5A, 0);
        step();
        step();
        check("t4_strobe_active", 32'(fifowr), 32'd0);
        nfull = 1'b0;
        wait_idle();
        nfull = 1'b1;
        check_counters();

        // 5. Reset mid-STROBE
        send(8'hC3, 0);
        step();
        step();
        check("t5_in_strobe", 32'(fifowr), 32'd0);
        rst = 1'b1;
        #1;
        check("t5_ready_in_rst", 32'(s_ready), 32'd0);
        step();
        check("t5_fifowr", 32'(fifowr), 32'd1);
        check("t5_in_data", 32'(in_data), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        exp_q.delete();
        exp_wr    = 0;
        exp_stall = 0;
        check_counters();
        rst = 1'b0;
        #1;
        check("t5_s_ready", 32'(s_ready), 32'd1);

        // Random traffic; enough writes to wrap wr_count at this counter width
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 5)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) step();
        end
        wait_idle();
        check_counters();

        // Long stall saturates stall_count
        send(8'hE7, 40);
        wait_idle();
        check_counters();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
